// File: rtl/spi_slave_param.sv
// spi_slave_param: parametrised SPI slave (WIDTH bits per word, any CPOL/CPHA,
// MSB- or LSB-first) with one-word TX and RX buffers using valid/ready.
// SCK, SS and MOSI are oversampled by clk through 2-flop synchronisers.
// Optional feature macro: SPI_SLAVE_OVERRUN_EN. When it is defined, a word that
// completes while rx_data is still unconsumed is dropped and the sticky overrun
// flag sets. When it is undefined, the new word overwrites rx_data and overrun
// stays 0.
module spi_slave_param #(
  parameter int WIDTH     = 24,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ss,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic          SCK_IDLE = (CPOL != 0) ? 1'b1 : 1'b0;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  // Bit currently presented on MISO for a given shift register value.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    logic b;
    if (LSB_FIRST != 0) b = v[0];
    else                b = v[WIDTH-1];
    return b;
  endfunction

  logic ss_meta_q, ss_meta_d, ss_sync_q, ss_sync_d, ss_prev_q, ss_prev_d;
  logic sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
  logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d, mosi_smp_q, mosi_smp_d;
  logic armed_q, armed_d, busy_q, busy_d;
  logic start_stb_q, start_stb_d, stop_stb_q, stop_stb_d;
  logic smp_stb_q, smp_stb_d, shf_stb_q, shf_stb_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, hold_q, hold_d, rx_data_q, rx_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
  logic overrun_q, overrun_d, miso_q, miso_d;
  logic sck_lead_s, sck_trail_s, active_s;
  logic load_s, done_s;
  logic [WIDTH-1:0] shifted_s, load_word_s;

  // Front end: synchroniser chains, arming after reset, and SCK/SS event strobes.
  always_comb begin
    ss_meta_d   = ss;
    ss_sync_d   = ss_meta_q;
    ss_prev_d   = ss_sync_q;
    sck_meta_d  = sck;
    sck_sync_d  = sck_meta_q;
    sck_prev_d  = sck_sync_q;
    mosi_meta_d = mosi;
    mosi_sync_d = mosi_meta_q;
    mosi_smp_d  = mosi_sync_q;
    // Nothing is decoded until SS has been seen high since reset.
    armed_d     = armed_q | ss_sync_q;
    active_s    = armed_q & ~ss_sync_q;
    busy_d      = active_s;
    start_stb_d = armed_q & ~ss_sync_q & ss_prev_q;
    stop_stb_d  = armed_q & ss_sync_q & ~ss_prev_q;
    sck_lead_s  = (sck_prev_q == SCK_IDLE) && (sck_sync_q != SCK_IDLE);
    sck_trail_s = (sck_prev_q != SCK_IDLE) && (sck_sync_q == SCK_IDLE);
    if (CPHA != 0) begin
      smp_stb_d = active_s & sck_trail_s;
      shf_stb_d = active_s & sck_lead_s;
    end else begin
      smp_stb_d = active_s & sck_lead_s;
      shf_stb_d = active_s & sck_trail_s;
    end
  end

  // Datapath: shift register, bit counter, word loads, TX holding and RX buffers.
  always_comb begin
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    miso_d      = miso_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    overrun_d   = overrun_q;
    load_s      = 1'b0;
    done_s      = 1'b0;

    if (LSB_FIRST != 0) shifted_s = {mosi_smp_q, shreg_q[WIDTH-1:1]};
    else                shifted_s = {shreg_q[WIDTH-2:0], mosi_smp_q};

    if (hold_full_q) load_word_s = hold_q;
    else             load_word_s = {WIDTH{1'b0}};

    if (stop_stb_q) begin
      // Abort: drop the partial word, keep the shift register contents.
      cnt_d = {CW{1'b0}};
    end else if (start_stb_q) begin
      cnt_d  = {CW{1'b0}};
      load_s = 1'b1;
    end else if (smp_stb_q) begin
      shreg_d = shifted_s;
      if (cnt_q == LAST_BIT) begin
        cnt_d  = {CW{1'b0}};
        done_s = 1'b1;
        load_s = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (shf_stb_q) begin
      miso_d = out_bit(shreg_q);
    end else begin
      cnt_d = cnt_q;
    end

    if (load_s) begin
      shreg_d     = load_word_s;
      hold_full_d = 1'b0;
      if (CPHA == 0) miso_d = out_bit(load_word_s);
      else           miso_d = miso_q;
    end else begin
      hold_full_d = hold_full_q;
    end

    // A write in the same cycle as a load lands after the load has emptied it.
    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end

    if (done_s) begin
      if (rx_valid_q && !rx_ready) begin
`ifdef SPI_SLAVE_OVERRUN_EN
        overrun_d = 1'b1;
`else
        rx_data_d = shifted_s;
`endif
      end else begin
        rx_data_d  = shifted_s;
        rx_valid_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end else begin
      rx_valid_d = rx_valid_q;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_meta_q   <= 1'b0;
      ss_sync_q   <= 1'b0;
      ss_prev_q   <= 1'b0;
      sck_meta_q  <= SCK_IDLE;
      sck_sync_q  <= SCK_IDLE;
      sck_prev_q  <= SCK_IDLE;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      mosi_smp_q  <= 1'b0;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      start_stb_q <= 1'b0;
      stop_stb_q  <= 1'b0;
      smp_stb_q   <= 1'b0;
      shf_stb_q   <= 1'b0;
      shreg_q     <= {WIDTH{1'b0}};
      hold_q      <= {WIDTH{1'b0}};
      rx_data_q   <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      hold_full_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      ss_meta_q   <= ss_meta_d;
      ss_sync_q   <= ss_sync_d;
      ss_prev_q   <= ss_prev_d;
      sck_meta_q  <= sck_meta_d;
      sck_sync_q  <= sck_sync_d;
      sck_prev_q  <= sck_prev_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      mosi_smp_q  <= mosi_smp_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      start_stb_q <= start_stb_d;
      stop_stb_q  <= stop_stb_d;
      smp_stb_q   <= smp_stb_d;
      shf_stb_q   <= shf_stb_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      rx_data_q   <= rx_data_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      miso_q      <= miso_d;
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = busy_q;
  assign busy     = busy_q;
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: instance 0 is WIDTH=24 mode 0 MSB-first, instance 1
// is WIDTH=8 mode 3 LSB-first. A behavioural SPI master drives random words and
// compares received/transmitted words against what it sent and preloaded.
module tb_spi_slave_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic ss_b[2], sck_b[2], mosi_b[2], tx_valid_b[2], rx_ready_b[2];
  logic miso_w[2], oe_w[2], txr_w[2], rxv_w[2], busy_w[2], ovr_w[2];
  logic [23:0] tx_data0, rx_data0;
  logic [7:0]  tx_data1, rx_data1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] mosi_words[4];
  logic [31:0] miso_got[4];
  logic [31:0] rxq0[$];
  logic [31:0] rxq1[$];

  spi_slave_param dut0 (
    .clk(clk), .rst(rst), .ss(ss_b[0]), .sck(sck_b[0]), .mosi(mosi_b[0]),
    .miso(miso_w[0]), .miso_oe(oe_w[0]), .tx_data(tx_data0), .tx_valid(tx_valid_b[0]),
    .tx_ready(txr_w[0]), .rx_data(rx_data0), .rx_valid(rxv_w[0]), .rx_ready(rx_ready_b[0]),
    .busy(busy_w[0]), .overrun(ovr_w[0]));

  spi_slave_param #(.WIDTH(8), .CPOL(1), .CPHA(1), .LSB_FIRST(1)) dut1 (
    .clk(clk), .rst(rst), .ss(ss_b[1]), .sck(sck_b[1]), .mosi(mosi_b[1]),
    .miso(miso_w[1]), .miso_oe(oe_w[1]), .tx_data(tx_data1), .tx_valid(tx_valid_b[1]),
    .tx_ready(txr_w[1]), .rx_data(rx_data1), .rx_valid(rxv_w[1]), .rx_ready(rx_ready_b[1]),
    .busy(busy_w[1]), .overrun(ovr_w[1]));

  // Consumer monitor: records every word handed over by rx_valid && rx_ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (rxv_w[0] && rx_ready_b[0]) rxq0.push_back({8'h00, rx_data0});
      if (rxv_w[1] && rx_ready_b[1]) rxq1.push_back({24'h000000, rx_data1});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int cfg_w(input int sel);
    return (sel == 1) ? 8 : 24;
  endfunction

  function automatic logic [31:0] wmask(input int sel);
    return (32'h1 << cfg_w(sel)) - 32'h1;
  endfunction

  // Bit position within the word for the i-th bit on the wire.
  function automatic int pos(input int sel, input int i);
    int bi;
    bi = i % cfg_w(sel);
    return (sel == 1) ? bi : cfg_w(sel) - 1 - bi;
  endfunction

  function automatic logic [31:0] rxd(input int sel);
    return (sel == 1) ? {24'h000000, rx_data1} : {8'h00, rx_data0};
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 1) ? rxq1.size() : rxq0.size();
  endfunction

  task automatic qclear();
    rxq0.delete();
    rxq1.delete();
  endtask

  task automatic qpop(input int sel, output logic [31:0] v);
    v = 32'hDEAD_BEEF;
    if (sel == 1) begin
      if (rxq1.size() > 0) v = rxq1.pop_front();
    end else begin
      if (rxq0.size() > 0) v = rxq0.pop_front();
    end
  endtask

  task automatic half();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input int sel, input string tag);
    check_eq($sformatf("%s_miso%0d", tag, sel), 32'(miso_w[sel]), 32'h0);
    check_eq($sformatf("%s_oe%0d", tag, sel), 32'(oe_w[sel]), 32'h0);
    check_eq($sformatf("%s_txready%0d", tag, sel), 32'(txr_w[sel]), 32'h1);
    check_eq($sformatf("%s_rxvalid%0d", tag, sel), 32'(rxv_w[sel]), 32'h0);
    check_eq($sformatf("%s_rxdata%0d", tag, sel), rxd(sel), 32'h0);
    check_eq($sformatf("%s_busy%0d", tag, sel), 32'(busy_w[sel]), 32'h0);
    check_eq($sformatf("%s_overrun%0d", tag, sel), 32'(ovr_w[sel]), 32'h0);
  endtask

  // Write one word into the TX holding register, bounded wait for tx_ready.
  task automatic tx_write(input int sel, input logic [31:0] data);
    bit ok;
    ok = 1'b0;
    if (sel == 1) tx_data1 = data[7:0];
    else          tx_data0 = data[23:0];
    tx_valid_b[sel] = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (txr_w[sel]) ok = 1'b1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    tx_valid_b[sel] = 1'b0;
    check_eq("tx_accept", 32'(ok), 32'h1);
    @(negedge clk);
    check_eq("tx_full", 32'(txr_w[sel]), 32'h0);
    #1;
  endtask

  // Behavioural SPI master: nbits clocks from mosi_words, miso collected into miso_got.
  task automatic xfer(input int sel, input int nbits, input int rst_bit, input bit keep_ss);
    logic cpol;
    int   w;
    cpol = (sel == 1);
    w    = cfg_w(sel);
    for (int k = 0; k < 4; k++) miso_got[k] = 32'h0;
    ss_b[sel] = 1'b0;
    if (sel == 0) mosi_b[sel] = mosi_words[0][pos(sel, 0)];
    half();
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_bit) rst = 1'b1;
      if (sel == 1) mosi_b[sel] = mosi_words[i / w][pos(sel, i)];
      else          miso_got[i / w][pos(sel, i)] = miso_w[sel];
      sck_b[sel] = ~cpol;
      half();
      if (i == rst_bit) rst = 1'b0;
      if (sel == 1) miso_got[i / w][pos(sel, i)] = miso_w[sel];
      else if (i + 1 < nbits) mosi_b[sel] = mosi_words[(i + 1) / w][pos(sel, i + 1)];
      sck_b[sel] = cpol;
      half();
    end
    if (!keep_ss) begin
      ss_b[sel] = 1'b1;
      half();
      half();
    end
  endtask

  // Single-word frame with an optional preload, checked against the model.
  task automatic one_word(input int sel, input bit pre, input logic [31:0] txw,
                          input logic [31:0] rxw, input string tag);
    logic [31:0] got;
    qclear();
    if (pre) tx_write(sel, txw);
    mosi_words[0] = rxw;
    xfer(sel, cfg_w(sel), -1, 1'b0);
    check_eq({tag, "_rxcount"}, 32'(qsize(sel)), 32'h1);
    qpop(sel, got);
    check_eq({tag, "_rxword"}, got, rxw);
    check_eq({tag, "_misoword"}, miso_got[0], pre ? txw : 32'h0);
    check_eq({tag, "_txready"}, 32'(txr_w[sel]), 32'h1);
  endtask

  initial begin
    logic [31:0] a, b, got, exp_rx;
    bit pre;
    int sel;
    rst = 1'b1;
    ss_b[0] = 1'b1; ss_b[1] = 1'b1;
    sck_b[0] = 1'b0; sck_b[1] = 1'b1;
    mosi_b[0] = 1'b0; mosi_b[1] = 1'b0;
    tx_valid_b[0] = 1'b0; tx_valid_b[1] = 1'b0;
    rx_ready_b[0] = 1'b1; rx_ready_b[1] = 1'b1;
    tx_data0 = 24'h0; tx_data1 = 8'h0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_idle(0, "reset");
    check_idle(1, "reset");

    // Mode 0, 24 bits, directed words.
    one_word(0, 1'b1, 32'h00A5C3F0, 32'h00123456, "m0");
    // Mode 3, LSB first, 8 bits: MISO order 1,0,0,0,0,0,0,1.
    one_word(1, 1'b1, 32'h00000081, 32'h0000003C, "m3");

    // Randomised single-word frames on both configurations.
    for (int it = 0; it < 8; it++) begin
      sel = it % 2;
      a   = $urandom() & wmask(sel);
      b   = $urandom() & wmask(sel);
      pre = 1'($urandom_range(0, 1));
      one_word(sel, pre, a, b, $sformatf("rnd%0d", it));
    end

    // Two back-to-back words, only the first preloaded.
    qclear();
    a = $urandom() & wmask(0);
    tx_write(0, a);
    mosi_words[0] = $urandom() & wmask(0);
    mosi_words[1] = $urandom() & wmask(0);
    xfer(0, 48, -1, 1'b0);
    check_eq("two_miso0", miso_got[0], a);
    check_eq("two_miso1", miso_got[1], 32'h0);
    check_eq("two_count", 32'(qsize(0)), 32'h2);
    qpop(0, got);
    check_eq("two_rx0", got, mosi_words[0]);
    qpop(0, got);
    check_eq("two_rx1", got, mosi_words[1]);

    // Two words while the consumer stalls.
    qclear();
    rx_ready_b[0] = 1'b0;
    mosi_words[0] = 32'h00111111;
    mosi_words[1] = 32'h00222222;
    xfer(0, 48, -1, 1'b0);
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_rx = 32'h00111111;
    check_eq("ovr_flag", 32'(ovr_w[0]), 32'h1);
`else
    exp_rx = 32'h00222222;
    check_eq("ovr_flag", 32'(ovr_w[0]), 32'h0);
`endif
    check_eq("ovr_rxvalid", 32'(rxv_w[0]), 32'h1);
    check_eq("ovr_rxdata", rxd(0), exp_rx);
    rx_ready_b[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_eq("ovr_drained", 32'(rxv_w[0]), 32'h0);
    check_eq("ovr_count", 32'(qsize(0)), 32'h1);
    qpop(0, got);
    check_eq("ovr_word", got, exp_rx);

    // Abort after 10 bits, then a full frame.
    qclear();
    mosi_words[0] = $urandom() & wmask(0);
    xfer(0, 10, -1, 1'b0);
    check_eq("abort_none", 32'(qsize(0)), 32'h0);
    mosi_words[0] = 32'h00ABCDEF;
    xfer(0, 24, -1, 1'b0);
    check_eq("abort_count", 32'(qsize(0)), 32'h1);
    qpop(0, got);
    check_eq("abort_word", got, 32'h00ABCDEF);

    // Reset mid-frame with SS held low for the remaining edges.
    qclear();
    mosi_words[0] = $urandom() & wmask(0);
    xfer(0, 24, 8, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check_idle(0, "midrst");
    check_eq("midrst_none", 32'(qsize(0)), 32'h0);
    ss_b[0] = 1'b1;
    half();
    half();
    one_word(0, 1'b1, $urandom() & wmask(0), $urandom() & wmask(0), "post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
